// File: rtl/alu_pkg.sv
// Shared definitions for alu_sequencer: FSM states, opcode constants, flag bit indices.
// The DIV_ITER_EN build option selects the iterative divider for opcode DIV.
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    DIVWAIT,
    WB,
    HALTED,
    FAULT
  } state_t;

  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_DIV     = 4'h7;
  localparam logic [3:0] OP_ALU_MAX = 4'h9;
  localparam logic [3:0] OP_CMP     = 4'hA;
  localparam logic [3:0] OP_LD      = 4'hB;
  localparam logic [3:0] OP_BR      = 4'hC;
  localparam logic [3:0] OP_NOP_D   = 4'hD;
  localparam logic [3:0] OP_NOP_E   = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_P = 0;

  localparam logic [2:0] FLAGS_RESET = 3'b010;

  // Exactly one of n/z/p is set for any 16-bit signed value.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    nzp_of = '0;
    if (v[15])
      nzp_of[FLAG_N] = 1'b1;
    else if (v == '0)
      nzp_of[FLAG_Z] = 1'b1;
    else
      nzp_of[FLAG_P] = 1'b1;
  endfunction

endpackage

// File: rtl/alu_sequencer_div_iter.sv
// 16-cycle unsigned restoring divider with a start/done handshake.
// Only instantiated by alu_sequencer when DIV_ITER_EN is defined.
module div_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient
);

  logic        running;
  logic [3:0]  cnt;
  logic [15:0] rem;
  logic [15:0] dvs;
  logic [16:0] rem_sh;
  logic [16:0] diff;

  // A zero divisor never borrows, so the quotient saturates to all ones.
  assign rem_sh = {rem, quotient[15]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign done   = running && (cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (start && !running) begin
      running  <= 1'b1;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end else if (running) begin
      if (!diff[16]) begin
        rem      <= diff[15:0];
        quotient <= {quotient[14:0], 1'b1};
      end else begin
        rem      <= rem_sh[15:0];
        quotient <= {quotient[14:0], 1'b0};
      end
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external ALU through FETCH/DECODE/EXEC/WB.
// Define DIV_ITER_EN to execute opcode DIV on the iterative divider; otherwise DIV is a NOP.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter logic [15:0] RESET_IP     = 16'h0000,
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] alu_regA,
  output logic [15:0] alu_regB,
  output logic [15:0] alu_imm,
  output logic [15:0] alu_opcode,
  input  logic [15:0] alu_res,
  output logic [2:0]  flags_nzp,
  output logic [15:0] ip,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  state_t      state;
  logic [15:0] instr;
  logic [15:0] res;
  logic [15:0] regs [8];
  logic [15:0] wait_cnt;

  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [15:0] imm_sext;
  logic [15:0] br_off;
  logic [15:0] ip_inc;
  logic [15:0] ip_next;
  logic        wr_en;
  logic        flag_en;
  logic [15:0] wr_data;

  assign op       = instr[15:12];
  assign rd       = instr[11:9];
  assign rs       = instr[2:0];
  assign imm_sext = {{11{instr[4]}}, instr[4:0]};
  assign br_off   = {{7{instr[8]}}, instr[8:0]};
  assign ip_inc   = ip + 16'd1;

`ifdef DIV_ITER_EN
  logic        div_start;
  logic        div_done;
  logic [15:0] div_quo;

  // Operands come from the DECODE-registered ALU drive, stable through DIVWAIT.
  assign div_start = (state == EXEC) && (op == OP_DIV);

  div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (alu_regA),
    .divisor  (alu_regB),
    .done     (div_done),
    .quotient (div_quo)
  );
`endif

  always_comb begin
    ip_next = ip_inc;
    if ((op == OP_BR) && ((instr[11:9] & flags_nzp) != '0))
      ip_next = ip_inc + br_off;
  end

  always_comb begin
    wr_en   = 1'b0;
    flag_en = 1'b0;
    wr_data = res;
    if ((op <= OP_ALU_MAX) && (op != OP_DIV)) begin
      wr_en   = 1'b1;
      flag_en = 1'b1;
    end
    if (op == OP_CMP)
      flag_en = 1'b1;
    if (op == OP_LD) begin
      wr_en   = 1'b1;
      wr_data = instr[8] ? alu_regB : {8'h00, instr[7:0]};
    end
`ifdef DIV_ITER_EN
    if (op == OP_DIV) begin
      wr_en   = 1'b1;
      flag_en = 1'b1;
      wr_data = div_quo;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ip         <= RESET_IP;
      for (int unsigned i = 0; i < 8; i++)
        regs[i] <= '0;
      flags_nzp  <= FLAGS_RESET;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      alu_regA   <= '0;
      alu_regB   <= '0;
      alu_imm    <= '0;
      alu_opcode <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      instr      <= '0;
      res        <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= ip;
            wait_cnt  <= '0;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_data;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else if (wait_cnt == 16'(IMEM_TIMEOUT - 1)) begin
            imem_req <= 1'b0;
            fault    <= 1'b1;
            state    <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DECODE: begin
          alu_regA   <= regs[rd];
          alu_regB   <= regs[rs];
          alu_imm    <= imm_sext;
          alu_opcode <= (op == OP_CMP) ? {OP_SUB, instr[11:0]} : instr;
          state      <= EXEC;
        end
        EXEC: begin
          res <= alu_res;
`ifdef DIV_ITER_EN
          state <= (op == OP_DIV) ? DIVWAIT : WB;
`else
          state <= WB;
`endif
        end
`ifdef DIV_ITER_EN
        DIVWAIT: begin
          if (div_done)
            state <= WB;
        end
`endif
        WB: begin
          if (wr_en)
            regs[rd] <= wr_data;
          if (flag_en)
            flags_nzp <= nzp_of(wr_data);
          if (op == OP_HALT) begin
            state  <= HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state     <= FETCH;
            ip        <= ip_next;
            imem_req  <= 1'b1;
            imem_addr <= ip_next;
            wait_cnt  <= '0;
          end
        end
        HALTED: begin
          if (start) begin
            state     <= FETCH;
            halted    <= 1'b0;
            busy      <= 1'b1;
            ip        <= RESET_IP;
            imem_req  <= 1'b1;
            imem_addr <= RESET_IP;
            wait_cnt  <= '0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU and instruction memory.
// Divide scenarios expect the DIV_ITER_EN build when that macro is defined.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] alu_regA, alu_regB, alu_imm, alu_opcode;
  logic [15:0] alu_res;
  logic [2:0]  flags_nzp;
  logic [15:0] ip;
  logic        busy, halted, fault;

  logic        ack_en = 1'b1;
  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;

  alu_sequencer #(.RESET_IP(16'h0000), .IMEM_TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_regA   (alu_regA),
    .alu_regB   (alu_regB),
    .alu_imm    (alu_imm),
    .alu_opcode (alu_opcode),
    .alu_res    (alu_res),
    .flags_nzp  (flags_nzp),
    .ip         (ip),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  assign imem_ack  = imem_req && ack_en;
  assign imem_data = mem[imem_addr[7:0]];

  // Behavioural ALU: op 1 = add, op 2 = subtract, bit 5 selects the immediate operand.
  logic [15:0] alu_b;
  assign alu_b = alu_opcode[5] ? alu_imm : alu_regB;
  always_comb begin
    case (alu_opcode[15:12])
      4'h1:    alu_res = alu_regA + alu_b;
      4'h2:    alu_res = alu_regA - alu_b;
      default: alu_res = alu_regA ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic next_fetch(input string tag, input logic [15:0] addr, input int exp_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 200);
    check({tag, "_req"}, imem_req, 1);
    check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_cyc"}, n, exp_cyc);
  endtask

  task automatic wait_halt(input string tag, input logic [15:0] exp_ip);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 50);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ip"}, ip, exp_ip);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hD000;

    // Reset state
    do_reset();
    check("rst_ip", ip, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_flags", flags_nzp, 3'b010);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_alu", {alu_regA, alu_opcode}, 32'h0);

    // LD R1,#5; LD R2,#3; ADD R1,R2; CMP R2,R1; HALT
    mem[0] = 16'hB205; mem[1] = 16'hB403; mem[2] = 16'h1202;
    mem[3] = 16'hA401; mem[4] = 16'hF000;
    start_pulse();
    next_fetch("a0", 16'h0000, 1);
    check("a0_busy", busy, 1);
    next_fetch("a1", 16'h0001, 4);
    check("ld_r1", dut.regs[1], 16'h0005);
    check("ld_flags", flags_nzp, 3'b010);
    next_fetch("a2", 16'h0002, 4);
    check("ld_r2", dut.regs[2], 16'h0003);
    next_fetch("a3", 16'h0003, 4);
    check("add_r1", dut.regs[1], 16'h0008);
    check("add_flags", flags_nzp, 3'b001);
    next_fetch("a4", 16'h0004, 4);
    check("cmp_flags", flags_nzp, 3'b100);
    check("cmp_r1", dut.regs[1], 16'h0008);
    check("cmp_r2", dut.regs[2], 16'h0003);
    wait_halt("halt_a", 16'h0004);

    // Restart: SUB R1,R1; BR nzp -> 0x10; BR p (not taken); CMP R0,R2; HALT
    mem[0] = 16'h2201; mem[1] = 16'hCE0E; mem[16] = 16'hC3FD;
    mem[17] = 16'hA002; mem[18] = 16'hF000;
    start_pulse();
    next_fetch("b0", 16'h0000, 1);
    check("restart_halted", halted, 0);
    check("keep_r1", dut.regs[1], 16'h0008);
    check("keep_flags", flags_nzp, 3'b100);
    next_fetch("b1", 16'h0001, 4);
    check("sub_r1", dut.regs[1], 16'h0000);
    check("sub_flags", flags_nzp, 3'b010);
    next_fetch("b_br_taken", 16'h0010, 4);
    next_fetch("b_br_p_z", 16'h0011, 4);
    next_fetch("b4", 16'h0012, 4);
    check("cmp_n_flags", flags_nzp, 3'b100);
    check("cmp_n_r0", dut.regs[0], 16'h0000);
    wait_halt("halt_b", 16'h0012);

    // Restart with n set: BR nzp -> 0x10; BR n -3 -> 0x0E; HALT
    mem[0] = 16'hCE0F; mem[16] = 16'hC9FD; mem[14] = 16'hF000;
    start_pulse();
    next_fetch("c0", 16'h0000, 1);
    next_fetch("c1", 16'h0010, 4);
    next_fetch("c_br_n_back", 16'h000E, 4);
    wait_halt("halt_c", 16'h000E);

    // Fetch timeout
    do_reset();
    ack_en = 1'b0;
    start_pulse();
    repeat (254) @(posedge clk);
    #1;
    check("to_254_fault", fault, 0);
    check("to_254_req", imem_req, 1);
    @(posedge clk);
    #1;
    check("to_fault", fault, 1);
    check("to_req", imem_req, 0);
    check("to_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    check("to_sticky", fault, 1);
    ack_en = 1'b1;
    do_reset();
    check("to_rst_fault", fault, 0);
    check("to_rst_ip", ip, 16'h0000);
    check("to_rst_busy", busy, 0);

    // Divide: LD R3,#100; LD R4,#7; DIV R3,R4; LD R5,#9; DIV R5,R0; HALT
    for (int i = 0; i < 32; i++) mem[i] = 16'hD000;
    mem[0] = 16'hB664; mem[1] = 16'hB807; mem[2] = 16'h7604;
    mem[3] = 16'hBA09; mem[4] = 16'h7A00; mem[5] = 16'hF000;
    start_pulse();
    next_fetch("d0", 16'h0000, 1);
    next_fetch("d1", 16'h0001, 4);
    next_fetch("d2", 16'h0002, 4);
`ifdef DIV_ITER_EN
    next_fetch("d3", 16'h0003, 20);
    check("div_r3", dut.regs[3], 16'd14);
    check("div_flags", flags_nzp, 3'b001);
    next_fetch("d4", 16'h0004, 4);
    next_fetch("d5", 16'h0005, 20);
    check("div0_r5", dut.regs[5], 16'hFFFF);
    check("div0_flags", flags_nzp, 3'b100);
`else
    next_fetch("d3", 16'h0003, 4);
    check("divnop_r3", dut.regs[3], 16'd100);
    check("divnop_flags", flags_nzp, 3'b010);
    next_fetch("d4", 16'h0004, 4);
    next_fetch("d5", 16'h0005, 4);
    check("divnop_r5", dut.regs[5], 16'd9);
`endif
    wait_halt("halt_d", 16'h0005);

    // Reset during the eighth divide-wait cycle
    do_reset();
    start_pulse();
    next_fetch("e0", 16'h0000, 1);
    next_fetch("e1", 16'h0001, 4);
    next_fetch("e2", 16'h0002, 4);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ip", ip, 16'h0000);
    check("mid_rst_r3", dut.regs[3], 16'h0000);
    check("mid_rst_r4", dut.regs[4], 16'h0000);
    check("mid_rst_flags", flags_nzp, 3'b010);
    check("mid_rst_alu", alu_regA, 16'h0000);
    repeat (3) @(negedge clk);
    check("mid_rst_idle", {busy, imem_req}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
